// File: rtl/fir_modsel_sequencer_if.sv
// Bus bundle between the FIR module-selector sequencer and its neighbours:
// coefficient stream in, job start pulses in, shared RAM bus and enables out.
// master = the sequencer, slave = the control / selector side.
interface fir_modsel_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              coeff_update;
    logic              coeff_valid;
    logic [DATA_W-1:0] coeff_data;
    logic              coeff_ready;
    logic              sample_start;
    logic [1:0]        module_sel;
    logic              csn_ram;
    logic              wrn_ram;
    logic [ADDR_W-1:0] addr_ram;
    logic [DATA_W-1:0] wt_dt_ram;
    logic              en_mul;
    logic              en_add_acc;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        input  coeff_update, coeff_valid, coeff_data, sample_start,
        output coeff_ready, module_sel, csn_ram, wrn_ram, addr_ram, wt_dt_ram,
               en_mul, en_add_acc, busy, done, overrun
    );

    modport slave (
        output coeff_update, coeff_valid, coeff_data, sample_start,
        input  coeff_ready, module_sel, csn_ram, wrn_ram, addr_ram, wt_dt_ram,
               en_mul, en_add_acc, busy, done, overrun
    );
endinterface

// File: rtl/fir_modsel_sequencer.sv
// Sequencer for the 4-way FIR module selector. LOAD streams coefficients into
// the four coefficient RAMs (module-major, tap order); RUN reads every tap of
// every module once and walks en_mul / en_add_acc behind the read strobe to
// cover RAM read latency and multiplier latency. All outputs are registered.
// Optional feature: define MODSEL_OVERRUN_DET_EN to get a sticky overrun flag
// for dropped start pulses; otherwise overrun is tied low.
module fir_modsel_sequencer #(
    parameter int NUM_TAPS = 10,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fir_modsel_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

    state_t            state, state_nx;
    logic [1:0]        mod, mod_nx;
    logic [ADDR_W-1:0] tap, tap_nx;
    logic              flush_cnt, flush_cnt_nx;
    // module index of the read that en_mul is currently serving
    logic [1:0]        sel_mul;

    logic              hs, last_coeff, strobe, rd_now;
    logic              csn_nx, wrn_nx, ready_nx, en_mul_nx, en_add_nx, busy_nx, done_nx;
    logic [1:0]        sel_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wt_nx;

    assign hs         = (state == S_LOAD) && bus.coeff_ready && bus.coeff_valid;
    assign last_coeff = (mod == 2'd3) && (tap == LAST_TAP);
    assign strobe     = hs || (state == S_RUN);
    assign rd_now     = !bus.csn_ram && bus.wrn_ram;

    // State and tap/module counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mod       <= 2'd0;
            tap       <= '0;
            flush_cnt <= 1'b0;
        end else begin
            state     <= state_nx;
            mod       <= mod_nx;
            tap       <= tap_nx;
            flush_cnt <= flush_cnt_nx;
        end
    end

    // Next-state: LOAD beats RUN on a same-cycle collision; LOAD ends one cycle
    // after ready drops so done lands two cycles after the last handshake
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.coeff_update)      state_nx = S_LOAD;
                else if (bus.sample_start) state_nx = S_RUN;
            end
            S_LOAD:  if (!bus.coeff_ready) state_nx = S_DONE;
            S_RUN:   if (last_coeff)       state_nx = S_FLUSH;
            S_FLUSH: if (flush_cnt)        state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values of counters and registered outputs
    always_comb begin
        mod_nx       = mod;
        tap_nx       = tap;
        flush_cnt_nx = 1'b0;
        csn_nx       = 1'b1;
        wrn_nx       = 1'b1;
        ready_nx     = 1'b0;
        wt_nx        = bus.wt_dt_ram;
        sel_nx       = bus.module_sel;
        addr_nx      = bus.addr_ram;
        en_mul_nx    = rd_now;
        en_add_nx    = bus.en_mul;
        busy_nx      = (state_nx != S_IDLE);
        done_nx      = (state == S_DONE);

        if (strobe) begin
            csn_nx  = 1'b0;
            wrn_nx  = (state != S_LOAD);
            sel_nx  = mod;
            addr_nx = tap;
            if (tap == LAST_TAP) begin
                tap_nx = '0;
                mod_nx = mod + 2'd1;
            end else begin
                tap_nx = tap + ADDR_W'(1);
            end
        end else if (rd_now) begin
            sel_nx = bus.module_sel;
        end else if (bus.en_mul) begin
            sel_nx = sel_mul;
        end else if (state_nx == S_IDLE) begin
            sel_nx = 2'd0;
        end

        if (!strobe && state_nx == S_IDLE) addr_nx = '0;
        if (hs) wt_nx = bus.coeff_data;

        if (state_nx == S_IDLE) begin
            mod_nx = 2'd0;
            tap_nx = '0;
        end

        if (state == S_IDLE && bus.coeff_update) ready_nx = 1'b1;
        else if (state == S_LOAD)                ready_nx = bus.coeff_ready && !(hs && last_coeff);

        if (state == S_FLUSH) flush_cnt_nx = !flush_cnt;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.csn_ram     <= 1'b1;
            bus.wrn_ram     <= 1'b1;
            bus.module_sel  <= 2'd0;
            bus.addr_ram    <= '0;
            bus.wt_dt_ram   <= '0;
            bus.coeff_ready <= 1'b0;
            bus.en_mul      <= 1'b0;
            bus.en_add_acc  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.csn_ram     <= csn_nx;
            bus.wrn_ram     <= wrn_nx;
            bus.module_sel  <= sel_nx;
            bus.addr_ram    <= addr_nx;
            bus.wt_dt_ram   <= wt_nx;
            bus.coeff_ready <= ready_nx;
            bus.en_mul      <= en_mul_nx;
            bus.en_add_acc  <= en_add_nx;
            bus.busy        <= busy_nx;
            bus.done        <= done_nx;
        end
    end

    // Delayed module index so en_add_acc reaches the module its read came from
    always_ff @(posedge clk) begin
        sel_mul <= bus.module_sel;
    end

`ifdef MODSEL_OVERRUN_DET_EN
    // Sticky flag for any start pulse that was dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.overrun <= 1'b0;
        end else if (((bus.coeff_update || bus.sample_start) && bus.busy) ||
                     (state == S_IDLE && bus.coeff_update && bus.sample_start)) begin
            bus.overrun <= 1'b1;
        end
    end
`else
    assign bus.overrun = 1'b0;
`endif
endmodule

// File: tb/tb_fir_modsel_sequencer.sv
// Scoreboard bench for fir_modsel_sequencer: stimulus pushes expected bus
// strobes, enable cycles and done cycles; a negedge monitor pops and compares.
module tb_fir_modsel_sequencer;
    localparam int NUM_TAPS = 10;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int TOT      = 4 * NUM_TAPS;
`ifdef MODSEL_OVERRUN_DET_EN
    localparam int OVR_EXP = 1;
`else
    localparam int OVR_EXP = 0;
`endif

    typedef struct {
        int cyc;
        bit wr;
        int sel;
        int addr;
        int data;
    } bus_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    bus_t bus_q[$];
    int   mul_q[$];
    int   add_q[$];
    int   done_q[$];
    bus_t e;
    int   exp_c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_modsel_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    fir_modsel_sequencer #(.NUM_TAPS(NUM_TAPS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // Monitor: every strobe / enable / done seen must match the head of its queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (!bus_if.csn_ram) begin
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_strobe cyc=%0d actual=strobe required=none", cyc);
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_cycle", cyc, e.cyc);
                    chk("bus_wrn", int'(bus_if.wrn_ram), e.wr ? 0 : 1);
                    chk("bus_sel", int'(bus_if.module_sel), e.sel);
                    chk("bus_addr", int'(bus_if.addr_ram), e.addr);
                    if (e.wr) chk("bus_data", int'(bus_if.wt_dt_ram), e.data);
                end
            end
            if (bus_if.en_mul) begin
                if (mul_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL en_mul cyc=%0d actual=1 required=0", cyc);
                end else begin
                    exp_c = mul_q.pop_front();
                    chk("en_mul_cycle", cyc, exp_c);
                end
            end
            if (bus_if.en_add_acc) begin
                if (add_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL en_add_acc cyc=%0d actual=1 required=0", cyc);
                end else begin
                    exp_c = add_q.pop_front();
                    chk("en_add_cycle", cyc, exp_c);
                end
            end
            if (bus_if.done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done cyc=%0d actual=1 required=0", cyc);
                end else begin
                    exp_c = done_q.pop_front();
                    chk("done_cycle", cyc, exp_c);
                end
            end
        end
    end

    // Called at a negedge; the pulse is sampled at edge n, returns at negedge cyc==n
    task automatic start_run(output int n);
        n = cyc + 1;
        bus_if.sample_start = 1'b1;
        @(negedge clk);
        bus_if.sample_start = 1'b0;
    endtask

    task automatic push_run(input int n, input int reads, input int muls, input int adds, input bit full);
        for (int k = 0; k < reads; k++) bus_q.push_back('{n + 1 + k, 1'b0, k / NUM_TAPS, k % NUM_TAPS, 0});
        for (int k = 0; k < muls; k++)  mul_q.push_back(n + 2 + k);
        for (int k = 0; k < adds; k++)  add_q.push_back(n + 3 + k);
        if (full) done_q.push_back(n + TOT + 3);
    endtask

    // LOAD job: valid held or toggled every other cycle, stops after `count` coefficients
    task automatic do_load(input bit toggle, input int count, input bit both);
        int u, k, sent;
        u = cyc + 1;
        bus_if.coeff_update = 1'b1;
        bus_if.sample_start = both;
        @(negedge clk);
        bus_if.coeff_update = 1'b0;
        bus_if.sample_start = 1'b0;
        chk("load_ready_up", int'(bus_if.coeff_ready), 1);
        chk("load_busy", int'(bus_if.busy), 1);
        k = 0;
        sent = 0;
        while (sent < count) begin
            if (!toggle || (k % 2) == 0) begin
                bus_if.coeff_valid = 1'b1;
                bus_if.coeff_data  = DATA_W'(16'h1000 + sent);
                bus_q.push_back('{u + k + 1, 1'b1, sent / NUM_TAPS, sent % NUM_TAPS, 16'h1000 + sent});
                sent++;
            end else begin
                bus_if.coeff_valid = 1'b0;
                bus_if.coeff_data  = 16'hDEAD;
            end
            k++;
            @(negedge clk);
        end
        bus_if.coeff_valid = 1'b0;
        if (count == TOT) begin
            done_q.push_back(u + k + 2);
            chk("load_ready_drop", int'(bus_if.coeff_ready), 0);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((bus_q.size() + mul_q.size() + add_q.size() + done_q.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", bus_q.size() + mul_q.size() + add_q.size() + done_q.size(), 0);
        chk("idle_busy", int'(bus_if.busy), 0);
        bus_q.delete(); mul_q.delete(); add_q.delete(); done_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus_if.coeff_update = 1'b0;
        bus_if.coeff_valid  = 1'b0;
        bus_if.coeff_data   = '0;
        bus_if.sample_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_csn", int'(bus_if.csn_ram), 1);
        chk("rst_wrn", int'(bus_if.wrn_ram), 1);
        chk("rst_busy", int'(bus_if.busy), 0);
        chk("rst_ready", int'(bus_if.coeff_ready), 0);
        chk("rst_sel", int'(bus_if.module_sel), 0);
        chk("rst_overrun", int'(bus_if.overrun), 0);
        @(negedge clk);

        // Reset for 3 cycles in the middle of RUN
        start_run(n);
        push_run(n, 5, 4, 3, 1'b0);
        while (cyc < n + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_csn", int'(bus_if.csn_ram), 1);
        chk("midrun_rst_wrn", int'(bus_if.wrn_ram), 1);
        chk("midrun_rst_busy", int'(bus_if.busy), 0);
        chk("midrun_rst_en_mul", int'(bus_if.en_mul), 0);
        chk("midrun_rst_en_add", int'(bus_if.en_add_acc), 0);
        chk("midrun_rst_done", int'(bus_if.done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain();

        // LOAD with valid held high
        do_load(1'b0, TOT, 1'b0);
        drain();

        // RUN after LOAD, with an extra start pulse mid-job
        start_run(n);
        push_run(n, TOT, TOT, TOT, 1'b1);
        while (cyc < n + 10) @(negedge clk);
        bus_if.sample_start = 1'b1;
        @(negedge clk);
        bus_if.sample_start = 1'b0;
        chk("overrun_midrun", int'(bus_if.overrun), OVR_EXP);
        while (cyc < n + TOT + 2) @(negedge clk);
        chk("flush_sel", int'(bus_if.module_sel), 3);
        chk("flush_csn", int'(bus_if.csn_ram), 1);
        @(negedge clk);
        chk("run_end_sel", int'(bus_if.module_sel), 0);
        chk("run_end_addr", int'(bus_if.addr_ram), 0);
        chk("run_end_busy", int'(bus_if.busy), 0);
        drain();

        // Same-cycle collision in IDLE: LOAD wins, sample start dropped
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("overrun_cleared", int'(bus_if.overrun), 0);
        do_load(1'b0, TOT, 1'b1);
        chk("overrun_collision", int'(bus_if.overrun), OVR_EXP);
        drain();

        // LOAD with valid toggled every other cycle
        do_load(1'b1, TOT, 1'b0);
        drain();

        // Reset after 17 writes, then a fresh LOAD restarts at sel=0 addr=0
        do_load(1'b0, 17, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midload_rst_busy", int'(bus_if.busy), 0);
        chk("midload_rst_csn", int'(bus_if.csn_ram), 1);
        chk("midload_rst_ready", int'(bus_if.coeff_ready), 0);
        chk("midload_rst_addr", int'(bus_if.addr_ram), 0);
        drain();
        do_load(1'b0, TOT, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
